ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the ID/EX opcode, func3, func7_mul flag and the forwarded operands. While it computes, it holds the pipeline with stall_muldiv, which is ORed into the core's stall_CPU. On completion it presents the 32-bit result to the EX result mux for the EX/MEM register.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per CALC cycle; legal 1, 2, 4
ITERS, XLEN/BITS_PER_CYCLE, derived localparam; CALC cycle count

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
ID_EX_opcode  in  7  opcode from ID/EX
ID_EX_func3  in  3  0..3 MUL/MULH/MULHSU/MULHU, 4..7 DIV/DIVU/REM/REMU
ID_EX_func7_mul  in  1  M-extension flag from ID/EX
op_a  in  XLEN  forwarded rs1 value
op_b  in  XLEN  forwarded rs2 value
stall_CPU  in  1  external hold (memory wait); ID/EX frozen while high
kill  in  1  interrupt/trap entry; aborts any operation
stall_muldiv  out  1  pipeline hold request
muldiv_valid  out  1  result valid for the instruction in EX
muldiv_result  out  XLEN  result
busy  out  1  FSM not IDLE

Behaviour:
- req = (ID_EX_opcode==7'b0110011) & ID_EX_func7_mul & ~kill.
- Reset (rst=0, async): state=IDLE, counter=0, all datapath regs=0. Outputs: stall_muldiv=0, muldiv_valid=0, muldiv_result=0, busy=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - stall_muldiv = req (combinational).
  - On req at clk edge: latch func3, op_a, op_b and the sign-fix flags; load counter=ITERS-1; go to CALC.
  - Request cycle is accepted even when stall_CPU=1, because ID/EX is held anyway.
- CALC:
  - stall_muldiv=1, busy=1.
  - Each cycle retires BITS_PER_CYCLE bits; counter decrements; goes to DONE when counter==0.
  - Exactly ITERS CALC cycles.
- DONE:
  - stall_muldiv=0, muldiv_valid=1, muldiv_result is registered and stable.
  - If stall_CPU=1, stay in DONE with the result held (no recompute).
  - Else go to IDLE next edge; ID/EX advances on the same edge, so the finished instruction cannot re-trigger.
- Latency: result valid ITERS+1 cycles after the request cycle; total stall_muldiv-high cycles = ITERS+1 (33 at defaults).
- kill (any state): next state IDLE, no result.
  - muldiv_valid=0 from the following cycle; stall_muldiv drops combinationally in the same cycle.
- Multiply: shift-add on |a|, |b|, 64-bit product.
  - Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned.
  - Negate the product if the signs differ.
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
- Divide: restoring division on magnitudes.
  - Quotient sign = sa^sb; remainder sign = sa (signed ops only).
  - Divisor==0: quotient=32'hFFFFFFFF, remainder=op_a; still takes the full ITERS cycles for fixed latency.
  - Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0.
- Back-to-back M ops: the second request is seen only in IDLE, one cycle after DONE; no overlap.
- Reset during CALC/DONE: immediate return to IDLE with all outputs at reset values.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: func3 0..3 use a single-cycle combinational 32x32 multiplier.
  - In IDLE, muldiv_valid=req & ~func3[2]; muldiv_result is the combinational product; stall_muldiv=0; no state change.
  - Division stays iterative, unchanged.
- Undefined: all eight ops use the iterative path described above.

Test Plan:
- MUL op_a=7, op_b=-3 (0xFFFFFFFD) -> stall_muldiv high 33 cycles, then muldiv_valid=1, result=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 20/0 -> 0xFFFFFFFF; REMU 20/0 -> 20; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; DIV -7/2 -> -3; REM -7/2 -> -1.
- Result arrives with stall_CPU=1 held 5 cycles -> DONE held, result stable, muldiv_valid=1 for 5 cycles; IDLE one cycle after stall_CPU falls; no restart.
- kill pulsed at CALC cycle 10 -> stall_muldiv=0 that cycle; IDLE next; no muldiv_valid. Repeat with rst=0 at CALC cycle 10 -> all outputs 0 immediately.
- MULDIV_FAST_MUL_EN defined: MUL 6×7 -> result=42 with muldiv_valid in the request cycle, stall_muldiv never high; DIVU 42/6 -> 7 after 33 stall cycles.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; holds the pipeline while computing.
// Optional build macro MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier for func3 0..3.
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      ID_EX_opcode,
  input  logic [2:0]      ID_EX_func3,
  input  logic            ID_EX_func7_mul,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            stall_CPU,
  input  logic            kill,
  output logic            stall_muldiv,
  output logic            muldiv_valid,
  output logic [XLEN-1:0] muldiv_result,
  output logic            busy
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          func3_q;
  logic [2*XLEN-1:0]   acc_q;    // product accumulator, or remainder in the low half
  logic [XLEN-1:0]     a_q;      // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [2*XLEN-1:0]   b_q;      // multiplicand (shifts left) or divisor in the low half
  logic [XLEN-1:0]     a_raw_q;
  logic                neg_q;
  logic                rneg_q;
  logic                dz_q;
  logic [XLEN-1:0]     result_q;

  logic                req;
  logic                start;
  logic                is_div;
  logic                a_signed;
  logic                b_signed;
  logic                sa;
  logic                sb;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic [2*XLEN-1:0]   acc_n;
  logic [XLEN-1:0]     a_n;
  logic [2*XLEN-1:0]   b_n;
  logic [XLEN:0]       rem_sh;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     final_res;

  assign req      = (ID_EX_opcode == 7'b0110011) & ID_EX_func7_mul & ~kill;
  assign is_div   = ID_EX_func3[2];
  assign a_signed = is_div ? ~ID_EX_func3[0] : (ID_EX_func3 != 3'd3);
  assign b_signed = is_div ? ~ID_EX_func3[0] : ~ID_EX_func3[1];
  assign sa       = a_signed & op_a[XLEN-1];
  assign sb       = b_signed & op_b[XLEN-1];
  assign mag_a    = sa ? -op_a : op_a;
  assign mag_b    = sb ? -op_b : op_b;

  // One CALC cycle: retire BITS_PER_CYCLE shift-add or restoring-divide steps.
  always_comb begin
    acc_n  = acc_q;
    a_n    = a_q;
    b_n    = b_q;
    rem_sh = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (func3_q[2]) begin
        rem_sh = {acc_n[XLEN-1:0], a_n[XLEN-1]};
        a_n    = {a_n[XLEN-2:0], 1'b0};
        if (rem_sh >= {1'b0, b_n[XLEN-1:0]}) begin
          rem_sh = rem_sh - {1'b0, b_n[XLEN-1:0]};
          a_n[0] = 1'b1;
        end
        acc_n = {{XLEN{1'b0}}, rem_sh[XLEN-1:0]};
      end else begin
        if (a_n[0]) acc_n = acc_n + b_n;
        a_n = a_n >> 1;
        b_n = b_n << 1;
      end
    end
  end

  // Divide-by-zero bypasses the sign fix so the quotient is all ones for any dividend sign.
  always_comb begin
    prod_fix = neg_q  ? -acc_n : acc_n;
    quo_fix  = neg_q  ? -a_n   : a_n;
    rem_fix  = rneg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    case (func3_q)
      3'd0:         final_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:         final_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:   final_res = dz_q ? {XLEN{1'b1}} : quo_fix;
      default:      final_res = dz_q ? a_raw_q : rem_fix;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic                fast_hit;
  logic [XLEN:0]       fast_a;
  logic [XLEN:0]       fast_b;
  logic [2*XLEN-1:0]   fast_prod;
  logic [XLEN-1:0]     fast_res;

  assign fast_hit  = req & ~is_div & (state_q == IDLE);
  assign start     = req & is_div;
  assign fast_a    = {a_signed & op_a[XLEN-1], op_a};
  assign fast_b    = {b_signed & op_b[XLEN-1], op_b};
  assign fast_prod = $signed(fast_a) * $signed(fast_b);
  assign fast_res  = (ID_EX_func3 == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign start     = req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_raw_q  <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Accepted even under stall_CPU: ID/EX is frozen so the operands stay put.
          if (start) begin
            state_q <= CALC;
            cnt_q   <= CW'(ITERS - 1);
            func3_q <= ID_EX_func3;
            acc_q   <= '0;
            a_q     <= mag_a;
            b_q     <= {{XLEN{1'b0}}, mag_b};
            a_raw_q <= op_a;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            dz_q    <= (op_b == '0);
          end
        end
        CALC: begin
          if (kill) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_n;
            a_q   <= a_n;
            b_q   <= b_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              result_q <= final_res;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          if (kill || !stall_CPU) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake: stall_muldiv holds ID/EX while an op is pending; muldiv_valid marks the one
  // cycle (or more, under stall_CPU) in which muldiv_result belongs to the instruction in EX.
  assign busy = (state_q != IDLE);
`ifdef MULDIV_FAST_MUL_EN
  assign stall_muldiv  = rst & (((state_q == IDLE) & start) | ((state_q == CALC) & ~kill));
  assign muldiv_valid  = (state_q == DONE) | (rst & fast_hit);
  assign muldiv_result = (rst & fast_hit) ? fast_res : result_q;
`else
  assign stall_muldiv  = rst & (((state_q == IDLE) & start) | ((state_q == CALC) & ~kill));
  assign muldiv_valid  = (state_q == DONE);
  assign muldiv_result = result_q;
`endif

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (default build: iterative path for all eight ops).
module tb_ex_muldiv_unit;

  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  ID_EX_opcode;
  logic [2:0]  ID_EX_func3;
  logic        ID_EX_func7_mul;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall_CPU;
  logic        kill;
  logic        stall_muldiv;
  logic        muldiv_valid;
  logic [31:0] muldiv_result;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .ID_EX_opcode(ID_EX_opcode), .ID_EX_func3(ID_EX_func3),
    .ID_EX_func7_mul(ID_EX_func7_mul), .op_a(op_a), .op_b(op_b), .stall_CPU(stall_CPU),
    .kill(kill), .stall_muldiv(stall_muldiv), .muldiv_valid(muldiv_valid),
    .muldiv_result(muldiv_result), .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: plain RV32M arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] pu;
    int          ia, ib;
    logic        ovf;
    sa = $signed(a);
    sb = $signed(b);
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Driver tasks
  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ID_EX_opcode    = 7'b0110011;
    ID_EX_func7_mul = 1'b1;
    ID_EX_func3     = f3;
    op_a            = a;
    op_b            = b;
  endtask

  task automatic drive_idle();
    ID_EX_opcode    = 7'b0010011;
    ID_EX_func7_mul = 1'b0;
    ID_EX_func3     = 3'($urandom_range(0, 7));
    op_a            = $urandom;
    op_b            = $urandom;
  endtask

  // Called at negedge+1 of the request cycle; returns at negedge+1 of the first non-stall cycle.
  task automatic wait_result(output int stalls, output logic vld, output logic [31:0] res);
    stalls = 0;
    while (stall_muldiv === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk); #1;
    end
    vld = muldiv_valid;
    res = muldiv_result;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0; kill = 1'b0; stall_CPU = 1'b0;
    drive_op(3'd0, 32'd7, 32'd3);
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (stall_muldiv !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", stall_muldiv); end
    n_tests++; if (muldiv_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", muldiv_valid); end
    n_tests++; if (muldiv_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h exp 0", muldiv_result); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (busy !== 1'b0 || stall_muldiv !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy %b stall %b exp 0 0", busy, stall_muldiv); end
  endtask

  logic [2:0]  d_f3  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd20, 32'd20,
                              32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFEC, 32'hFFFF_FFEC};
  logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'd0};
  logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd20,
                              32'h8000_0000, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC};

  task automatic test_directed();
    int          stalls;
    logic        vld;
    logic [31:0] res;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_op(d_f3[i], d_a[i], d_b[i]);
      #1;
      wait_result(stalls, vld, res);
      n_tests++; if (stalls !== LAT) begin n_fail++; $display("FAIL dir%0d_latency: got %0d exp %0d", i, stalls, LAT); end
      n_tests++; if (vld !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid: got %b exp 1", i, vld); end
      n_tests++; if (res !== d_exp[i]) begin n_fail++; $display("FAIL dir%0d_result f3=%0d a=%h b=%h: got %h exp %h", i, d_f3[i], d_a[i], d_b[i], res, d_exp[i]); end
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_tests++; if (busy !== 1'b0 || muldiv_valid !== 1'b0) begin n_fail++; $display("FAIL dir_return_idle: busy %b valid %b exp 0 0", busy, muldiv_valid); end
  endtask

  task automatic test_random();
    int          stalls;
    logic        vld;
    logic [31:0] res, a, b, e;
    logic [2:0]  f3;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      exp_q.push_back(ref_model(f3, a, b));
      @(negedge clk);
      drive_op(f3, a, b);
      #1;
      wait_result(stalls, vld, res);
      e = exp_q.pop_front();
      n_tests++; if (stalls !== LAT || vld !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_timing: stalls %0d valid %b exp %0d 1", i, stalls, vld, LAT); end
      n_tests++; if (res !== e) begin n_fail++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h: got %h exp %h", i, f3, a, b, res, e); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_stall_cpu();
    int          stalls;
    logic        vld;
    logic [31:0] res;
    logic [31:0] e;
    e = ref_model(3'd0, 32'd1234, 32'd5678);
    @(negedge clk);
    stall_CPU = 1'b1;
    drive_op(3'd0, 32'd1234, 32'd5678);
    #1;
    wait_result(stalls, vld, res);
    n_tests++; if (stalls !== LAT || vld !== 1'b1) begin n_fail++; $display("FAIL hold_timing: stalls %0d valid %b exp %0d 1", stalls, vld, LAT); end
    n_tests++; if (res !== e) begin n_fail++; $display("FAIL hold_result: got %h exp %h", res, e); end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); #1;
      n_tests++; if (muldiv_valid !== 1'b1 || busy !== 1'b1 || stall_muldiv !== 1'b0) begin n_fail++; $display("FAIL hold%0d_state: valid %b busy %b stall %b exp 1 1 0", i, muldiv_valid, busy, stall_muldiv); end
      n_tests++; if (muldiv_result !== e) begin n_fail++; $display("FAIL hold%0d_result: got %h exp %h", i, muldiv_result, e); end
    end
    stall_CPU = 1'b0;
    @(negedge clk);
    drive_idle();
    #1;
    n_tests++; if (busy !== 1'b0 || muldiv_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: busy %b valid %b exp 0 0", busy, muldiv_valid); end
    @(negedge clk); #1;
    n_tests++; if (busy !== 1'b0 || stall_muldiv !== 1'b0) begin n_fail++; $display("FAIL hold_no_restart: busy %b stall %b exp 0 0", busy, stall_muldiv); end
  endtask

  task automatic test_kill();
    int vcount;
    @(negedge clk);
    drive_op(3'd5, $urandom, 32'd3);
    repeat (10) @(negedge clk);
    #1;
    n_tests++; if (stall_muldiv !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL kill_pre: stall %b busy %b exp 1 1", stall_muldiv, busy); end
    kill = 1'b1;
    #1;
    n_tests++; if (stall_muldiv !== 1'b0) begin n_fail++; $display("FAIL kill_stall_drop: got %b exp 0", stall_muldiv); end
    @(negedge clk);
    kill = 1'b0;
    drive_idle();
    #1;
    n_tests++; if (busy !== 1'b0 || muldiv_valid !== 1'b0 || stall_muldiv !== 1'b0) begin n_fail++; $display("FAIL kill_idle: busy %b valid %b stall %b exp 0 0 0", busy, muldiv_valid, stall_muldiv); end
    vcount = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (muldiv_valid === 1'b1) vcount++;
    end
    n_tests++; if (vcount !== 0) begin n_fail++; $display("FAIL kill_no_result: valid seen %0d cycles exp 0", vcount); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_op(3'd1, $urandom, $urandom);
    repeat (10) @(negedge clk);
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy: got %b exp 1", busy); end
    rst = 1'b0;
    #1;
    n_tests++; if (stall_muldiv !== 1'b0 || muldiv_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: stall %b valid %b busy %b exp 0 0 0", stall_muldiv, muldiv_valid, busy); end
    n_tests++; if (muldiv_result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h exp 0", muldiv_result); end
    @(negedge clk); #1;
    n_tests++; if (stall_muldiv !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold: stall %b busy %b exp 0 0", stall_muldiv, busy); end
    drive_idle();
    rst = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: busy %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int          stalls;
    logic        vld;
    logic [31:0] res, a, b, e;
    logic [2:0]  f3;
    for (int k = 0; k < 3; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom_range(1, 1000);
      exp_q.push_back(ref_model(f3, a, b));
      @(negedge clk);
      drive_op(f3, a, b);
      #1;
      n_tests++; if (busy !== 1'b0 || stall_muldiv !== 1'b1 || muldiv_valid !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_accept: busy %b stall %b valid %b exp 0 1 0", k, busy, stall_muldiv, muldiv_valid); end
      wait_result(stalls, vld, res);
      e = exp_q.pop_front();
      n_tests++; if (stalls !== LAT || vld !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_timing: stalls %0d valid %b exp %0d 1", k, stalls, vld, LAT); end
      n_tests++; if (res !== e) begin n_fail++; $display("FAIL b2b%0d_result f3=%0d: got %h exp %h", k, f3, res, e); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall_cpu();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
